// File: rtl/decrypt_ecb_if.sv
// Handshake and data bundle between a SPECK decrypt core and its controller.
interface decrypt_ecb_if #(
    parameter int KEY_SIZE   = 128,
    parameter int BLOCK_SIZE = 64
);
    logic                      start;
    logic [2*BLOCK_SIZE-1:0]   ciphertext;
    logic [KEY_SIZE-1:0]       key;
    logic [2*BLOCK_SIZE-1:0]   plaintext;
    logic                      active;
    logic                      ready;

    modport master (
        output start, ciphertext, key,
        input  plaintext, active, ready
    );

    modport slave (
        input  start, ciphertext, key,
        output plaintext, active, ready
    );
endinterface

// File: rtl/decrypt_ecb.sv
// Iterative SPECK ECB decryption: NR_ROUNDS cycles of key expansion, then
// NR_ROUNDS cycles of inverse rounds using the stored round keys in reverse.
module decrypt_ecb #(
    parameter int KEY_SIZE   = 128,
    parameter int BLOCK_SIZE = 64,
    parameter int NR_ROUNDS  = 32
) (
    input  logic         clk,
    input  logic         rst,
    decrypt_ecb_if.slave bus
);
    localparam int N     = BLOCK_SIZE;
    localparam int M     = KEY_SIZE / BLOCK_SIZE;
    localparam int ALPHA = (N == 16) ? 7 : 8;
    localparam int BETA  = (N == 16) ? 2 : 3;
    localparam int CW    = (NR_ROUNDS > 1) ? $clog2(NR_ROUNDS) : 1;

    typedef logic [N-1:0] word_t;
    typedef enum logic [1:0] {StIdle, StKeyExp, StDec, StDone} state_t;

    function automatic word_t rol(input word_t v, input int s);
        return (v << s) | (v >> (N - s));
    endfunction

    function automatic word_t ror(input word_t v, input int s);
        return (v >> s) | (v << (N - s));
    endfunction

    state_t          r_state;
    state_t          w_state_next;
    logic [CW-1:0]   r_cnt;
    logic [2*N-1:0]  r_pt;
    word_t           r_k;
    word_t           r_l  [0:M-2];
    word_t           r_rk [0:NR_ROUNDS-1];
    word_t           r_x;
    word_t           r_y;

    logic            w_accept;
    logic            w_cnt_last;
    logic            w_cnt_zero;
    word_t           w_l_new;
    word_t           w_k_new;
    word_t           w_rk_cur;
    word_t           w_y_new;
    word_t           w_x_new;

    always_comb begin
        w_accept   = ((r_state == StIdle) || (r_state == StDone)) && bus.start;
        w_cnt_last = (r_cnt == CW'(NR_ROUNDS - 1));
        w_cnt_zero = (r_cnt == '0);
        w_l_new    = (r_k + ror(r_l[0], ALPHA)) ^ word_t'(r_cnt);
        w_k_new    = rol(r_k, BETA) ^ w_l_new;
        w_rk_cur   = r_rk[r_cnt];
        w_y_new    = ror(r_x ^ r_y, BETA);
        w_x_new    = rol((r_x ^ w_rk_cur) - w_y_new, ALPHA);
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle, StDone: if (bus.start) w_state_next = StKeyExp;
            StKeyExp:       if (w_cnt_last) w_state_next = StDec;
            StDec:          if (w_cnt_zero) w_state_next = StDone;
            default:        w_state_next = StIdle;
        endcase
    end

    // Counter runs up during key expansion and down during decryption,
    // so it doubles as the round-key index in both phases.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StIdle;
            r_cnt   <= '0;
            r_pt    <= '0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                StIdle, StDone: begin
                    if (bus.start) r_cnt <= '0;
                end
                StKeyExp: begin
                    if (w_cnt_last) r_cnt <= CW'(NR_ROUNDS - 1);
                    else            r_cnt <= r_cnt + 1'b1;
                end
                StDec: begin
                    if (w_cnt_zero) r_pt  <= {w_x_new, w_y_new};
                    else            r_cnt <= r_cnt - 1'b1;
                end
                default: r_cnt <= '0;
            endcase
        end
    end

    // Working registers need no reset: they are always reloaded on accept.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_x <= bus.ciphertext[2*N-1:N];
            r_y <= bus.ciphertext[N-1:0];
            r_k <= bus.key[N-1:0];
            for (int j = 0; j < M - 1; j++) begin
                r_l[j] <= bus.key[(j+1)*N +: N];
            end
        end else if (r_state == StKeyExp) begin
            r_rk[r_cnt] <= r_k;
            r_k         <= w_k_new;
            for (int j = 0; j < M - 2; j++) begin
                r_l[j] <= r_l[j+1];
            end
            r_l[M-2] <= w_l_new;
        end else if (r_state == StDec) begin
            r_x <= w_x_new;
            r_y <= w_y_new;
        end
    end

    assign bus.plaintext = r_pt;
    assign bus.active    = (r_state == StKeyExp) || (r_state == StDec);
    assign bus.ready     = (r_state == StDone);
endmodule

// File: tb/tb_decrypt_ecb.sv
// Directed bench for decrypt_ecb: 32-, 1- and 2-round instances side by side.
module tb_decrypt_ecb;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    decrypt_ecb_if #(.KEY_SIZE(128), .BLOCK_SIZE(64)) if32 ();
    decrypt_ecb_if #(.KEY_SIZE(128), .BLOCK_SIZE(64)) if1 ();
    decrypt_ecb_if #(.KEY_SIZE(128), .BLOCK_SIZE(64)) if2 ();

    decrypt_ecb #(.KEY_SIZE(128), .BLOCK_SIZE(64), .NR_ROUNDS(32)) u_dut32 (
        .clk (clk), .rst (rst), .bus (if32)
    );
    decrypt_ecb #(.KEY_SIZE(128), .BLOCK_SIZE(64), .NR_ROUNDS(1)) u_dut1 (
        .clk (clk), .rst (rst), .bus (if1)
    );
    decrypt_ecb #(.KEY_SIZE(128), .BLOCK_SIZE(64), .NR_ROUNDS(2)) u_dut2 (
        .clk (clk), .rst (rst), .bus (if2)
    );

    int errors = 0;
    int checks = 0;

    localparam logic [127:0] KAT_KEY = 128'h0f0e0d0c0b0a0908_0706050403020100;
    localparam logic [127:0] KAT_CT  = 128'ha65d985179783265_7860fedf5c570d18;
    localparam logic [127:0] KAT_PT  = 128'h6c61766975716520_7469206564616d20;

    typedef struct {
        int           sel;
        logic [127:0] key;
        logic [127:0] ct;
        logic [127:0] exp;
        int           lat;
        int           slen;
        int           g1;
        int           g2;
    } vec_t;

    function automatic logic [63:0] rol64(input logic [63:0] v, input int s);
        return (v << s) | (v >> (64 - s));
    endfunction

    function automatic logic [63:0] ror64(input logic [63:0] v, input int s);
        return (v >> s) | (v << (64 - s));
    endfunction

    // Reference SPECK128 decryption, m = 2.
    function automatic logic [127:0] speck_dec(input logic [127:0] k_in,
                                               input logic [127:0] c_in, input int nr);
        logic [63:0] k, l, x, y;
        logic [63:0] rk [0:63];
        k = k_in[63:0];
        l = k_in[127:64];
        for (int i = 0; i < nr; i++) begin
            rk[i] = k;
            l = (k + ror64(l, 8)) ^ 64'(i);
            k = rol64(k, 3) ^ l;
        end
        x = c_in[127:64];
        y = c_in[63:0];
        for (int r = nr - 1; r >= 0; r--) begin
            y = ror64(x ^ y, 3);
            x = rol64((x ^ rk[r]) - y, 8);
        end
        return {x, y};
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic set_in(input int sel, input logic s, input logic [127:0] k,
                          input logic [127:0] c);
        case (sel)
            0: begin if32.start = s; if32.key = k; if32.ciphertext = c; end
            1: begin if1.start  = s; if1.key  = k; if1.ciphertext  = c; end
            default: begin if2.start = s; if2.key = k; if2.ciphertext = c; end
        endcase
    endtask

    task automatic read_out(input int sel, output logic [127:0] pt, output logic a,
                            output logic r);
        case (sel)
            0: begin pt = if32.plaintext; a = if32.active; r = if32.ready; end
            1: begin pt = if1.plaintext;  a = if1.active;  r = if1.ready;  end
            default: begin pt = if2.plaintext; a = if2.active; r = if2.ready; end
        endcase
    endtask

    task automatic check_idle(input int sel, input string tag);
        logic [127:0] pt;
        logic a, r;
        read_out(sel, pt, a, r);
        check({tag, " plaintext"}, pt, 128'h0);
        check({tag, " active"}, 128'(a), 128'h0);
        check({tag, " ready"}, 128'(r), 128'h0);
    endtask

    // Start on E0, hold start for slen edges, glitch start with junk inputs after
    // edges g1/g2, and measure edges until ready.
    task automatic run_op(input vec_t v, input string tag);
        logic [127:0] pt;
        logic a, r, s, g;
        int lat;
        lat = -1;
        @(negedge clk);
        set_in(v.sel, 1'b1, v.key, v.ct);
        @(posedge clk);
        for (int e = 0; e < 200; e++) begin
            @(negedge clk);
            read_out(v.sel, pt, a, r);
            if (e == 0) begin
                check({tag, " active after accept"}, 128'(a), 128'h1);
                check({tag, " ready after accept"}, 128'(r), 128'h0);
            end
            check({tag, " active&ready overlap"}, 128'(a & r), 128'h0);
            g = (e == v.g1) || (e == v.g2);
            s = (e + 1 < v.slen) || g;
            set_in(v.sel, s, v.key ^ 128'h5a5a_1234_0000_ffff_0f0f_9999_aaaa_0001,
                   v.ct ^ 128'ha5a5_0000_4321_ffff_f0f0_6666_5555_8000);
            if (r) begin
                lat = e;
                break;
            end
            @(posedge clk);
        end
        check({tag, " latency"}, 128'(lat), 128'(v.lat));
        check({tag, " plaintext"}, pt, v.exp);
        check({tag, " active at done"}, 128'(a), 128'h0);
    endtask

    vec_t vecs[6];

    initial begin
        logic [127:0] pt;
        logic a, r;
        vec_t abort_v;

        vecs[0] = '{0, KAT_KEY, KAT_CT, KAT_PT, 64, 1, -1, -1};
        vecs[1] = '{1, 128'h0, 128'h0000000000000008_0000000000000000,
                    128'h0000000000000700_0000000000000001, 2, 1, -1, -1};
        vecs[2] = '{1, 128'h0, 128'h0, 128'h0, 2, 1, -1, -1};
        vecs[3] = '{2, 128'h472d4b6150645367_753778214125442a,
                    128'hff2d4b6150645364_353678214125442a,
                    speck_dec(128'h472d4b6150645367_753778214125442a,
                              128'hff2d4b6150645364_353678214125442a, 2), 4, 5, -1, -1};
        vecs[4] = '{0, 128'h0011223344556677_8899aabbccddeeff,
                    128'h1234567890abcdef_fedcba0987654321,
                    speck_dec(128'h0011223344556677_8899aabbccddeeff,
                              128'h1234567890abcdef_fedcba0987654321, 32), 64, 1, 5, 40};
        vecs[5] = '{0, KAT_KEY, KAT_CT, KAT_PT, 64, 1, 10, 50};

        rst = 1'b1;
        set_in(0, 1'b0, 128'h0, 128'h0);
        set_in(1, 1'b0, 128'h0, 128'h0);
        set_in(2, 1'b0, 128'h0, 128'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_idle(0, "reset n32");
        check_idle(1, "reset n1");
        check_idle(2, "reset n2");
        rst = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        check_idle(0, "idle n32");
        check_idle(2, "idle n2");

        for (int i = 0; i < 6; i++) begin
            run_op(vecs[i], $sformatf("vec%0d", i));
            if (i == 3) begin
                repeat (3) @(posedge clk);
                @(negedge clk);
                read_out(2, pt, a, r);
                check("n2 single op ready", 128'(r), 128'h1);
                check("n2 single op active", 128'(a), 128'h0);
                check("n2 single op plaintext", pt, vecs[3].exp);
            end
        end

        repeat (5) @(posedge clk);
        @(negedge clk);
        read_out(0, pt, a, r);
        check("hold ready", 128'(r), 128'h1);
        check("hold plaintext", pt, KAT_PT);

        // Abort mid-decryption, then a fresh run must still be correct.
        set_in(0, 1'b1, vecs[4].key, vecs[4].ct);
        @(posedge clk);
        @(negedge clk);
        set_in(0, 1'b0, vecs[4].key, vecs[4].ct);
        repeat (39) @(posedge clk);
        @(negedge clk);
        read_out(0, pt, a, r);
        check("pre-abort active", 128'(a), 128'h1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_idle(0, "abort n32");
        abort_v = vecs[0];
        run_op(abort_v, "after abort");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
